vga_scanout: RTL
================

# vga_scanout

Video read-side engine for the 160x120, 3-bit-colour frame buffer. The game's drawing path (draw FSM, drawers, draw mux) writes pixels into the buffer's port A. This block owns port B. It generates 640x480@60 Hz VGA timing from the 50 MHz clock, reads the buffer in raster order with 4x4 pixel replication, and drives the board DAC pins. It also gives the game FSM a frame-start pulse and a vblank level, so redraws can be aligned to blanking.

## Interface

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SW, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SW, 2, vertical sync width
- V_BP, 33, vertical back porch
- SCALE_SH, 2, log2 of the replication factor (640/160)
- FB_W, 160, frame-buffer width in pixels

Ports:
- clk, in, 1, 50 MHz system clock
- resetn, in, 1, synchronous, active-low reset
- rd_addr, out, 15, frame-buffer port-B address, y*FB_W+x
- rd_data, in, 3, port-B read data {R,G,B}; valid exactly one clk after rd_addr
- VGA_CLK, out, 1, 25 MHz pixel clock to the DAC
- VGA_HS, out, 1, horizontal sync, active low
- VGA_VS, out, 1, vertical sync, active low
- VGA_BLANK_N, out, 1, high only during visible pixels
- VGA_SYNC_N, out, 1, constant 1
- VGA_R / VGA_G / VGA_B, out, 10 each, colour channels
- frame_start, out, 1, one-clk pulse at the start of each frame
- vblank, out, 1, high while vc >= V_VIS

## Operation

**Pixel enable**
- pix_en toggles every clk: 0 out of reset, then 1, 0, 1, …
- pix_en is 1 on every second clk, giving 25 MHz.

**Counters**
- hc counts 0..H_TOTAL-1, where H_TOTAL = 800.
- vc counts 0..V_TOTAL-1, where V_TOTAL = 525.
- Both advance only on clk edges with pix_en=1.
- hc wraps to 0 after H_TOTAL-1. On that wrap, vc increments; vc wraps to 0 after V_TOTAL-1.

**Stage 0, combinational from hc/vc**
- visible = (hc < H_VIS) && (vc < V_VIS).
- hs_raw = ~(hc in [H_VIS+H_FP, H_VIS+H_FP+H_SW)).
- vs_raw = ~(vc in [V_VIS+V_FP, V_VIS+V_FP+V_SW)).
- fx = hc >> SCALE_SH; fy = vc >> SCALE_SH.

**Stage 1, registered on pix_en edges**
- rd_addr <= (fy<<7) + (fy<<5) + fx, i.e. fy*160+fx in 15-bit unsigned.
- Maximum in-range address is 19199.
- When !visible, rd_addr holds its previous value. Out-of-range addresses are never issued.
- visible, hs_raw and vs_raw are delayed into d_vis, d_hs, d_vs on the same edge.

**Stage 2, registered on the next pix_en edge**
- VGA_R <= {10{rd_data[2] & d_vis}}.
- VGA_G <= {10{rd_data[1] & d_vis}}.
- VGA_B <= {10{rd_data[0] & d_vis}}.
- VGA_BLANK_N <= d_vis; VGA_HS <= d_hs; VGA_VS <= d_vs.

**Status outputs**
- frame_start: registered. It is 1 for exactly one clk, in the cycle after the pix_en edge on which (hc,vc) wraps from (799,524) to (0,0).
- vblank: registered on pix_en edges from (next vc >= V_VIS).

**Write side**
- Port A writes are not seen by this block.
- A pixel written during scan-out appears in the same frame only if its address has not yet been read.

## Timing

Reset values (resetn=0 at a clk edge):
- hc=0, vc=0, pix_en=0, rd_addr=0.
- VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_CLK=0.
- frame_start=0, vblank=0.

Reset behaviour:
- Reset asserted mid-frame restarts timing at (0,0) on the next edge.
- No partial sync pulse is stretched; VGA_HS and VGA_VS return to 1 immediately.

Latency:
- The counter value at a pix_en edge appears on the DAC outputs two pix_en edges later (4 clk).
- Sync and blank signals are delayed identically, so they stay aligned with colour.

Memory read:
- rd_data is sampled one clk after rd_addr changes, inside the pixel period.

VGA_CLK:
- VGA_CLK = registered ~pix_en.
- Its rising edge falls midway between output updates, so DAC setup and hold are each one clk (20 ns).

Frame timing:
- HS low for 96 pixel periods per line.
- VS low for 2 lines (1600 pixel periods).
- Frame = 800*525*2 = 840,000 clk.

Replication:
- Each buffer pixel is output for 4 consecutive pixel periods on 4 consecutive lines.

## Test plan

1. **Reset release.** Hold resetn=0 for 5 clk, then release.
   - First pix_en edge at clk 2.
   - HS=VS=1 and BLANK_N=0 while held.
   - BLANK_N rises 4 clk after the first counted pixel (hc=0, vc=0).
2. **Line and frame timing.** Run two frames.
   - HS low for exactly 192 clk, period 1600 clk.
   - VS low for 3200 clk, period 840,000 clk.
   - frame_start pulses once per 840,000 clk, width 1 clk.
   - vblank is high for 45*1600 clk.
3. **Addressing.** Use a buffer model with data = address[2:0].
   - rd_addr sequence at line vc=0..3 is 0,0,0,0,1,1,1,1…159.
   - vc=4 starts at 160.
   - Last visible address is 19199; no address > 19199 ever appears.
4. **Colour and blank.** Fill the buffer with 3'b101.
   - Visible: R=10'h3FF, G=0, B=10'h3FF.
   - All channels are 0 whenever BLANK_N=0, including porches.
5. **Mid-frame reset.** Assert resetn=0 for 1 clk at vc=300, hc=400.
   - Next state is hc=vc=0 with outputs at reset values.
   - Subsequent HS period is 1600 clk with no glitch.
6. **Live update.** Write address 0 through a port-A model during vblank.
   - The new colour appears at output pixels (0..3, 0..3) of the next frame.
   - Pixel (4,0) is unchanged.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: read side of the 160x120 3-bit frame buffer.
// Generates 640x480@60 VGA timing from the 50 MHz clock, which gives 25 MHz
// pixel periods. It reads the buffer in raster order with 2^SCALE_SH x 2^SCALE_SH
// pixel replication and drives the board DAC pins. It also gives the game FSM a
// frame-start pulse and a vblank level.
// Ports:
//   clk, resetn          50 MHz clock, synchronous active-low reset
//   rd_addr / rd_data    frame-buffer port B (data valid one clk after address)
//   VGA_*                DAC pins (pixel clock, syncs, blank, 10-bit colour)
//   frame_start          one-clk pulse after the (last,last) -> (0,0) wrap
//   vblank               high while the line counter is in vertical blanking
module vga_scanout #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter int SCALE_SH = 2,
  parameter int FB_W     = 160
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        frame_start,
  output logic        vblank
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic          pix_en_reg;
  logic [HW-1:0] hc_reg, hc_next;
  logic [VW-1:0] vc_reg, vc_next;

  // Stage-0 decode of the current counter position
  logic          visible, hs_raw, vs_raw;
  logic [14:0]   fx, fy, rd_addr_next;

  // Stage-1 delayed controls
  logic          d_vis_reg, d_hs_reg, d_vs_reg;

  // Colour bits gated by the delayed visible flag, index 2=R 1=G 0=B
  logic [2:0]    chan_on;

  assign VGA_SYNC_N = 1'b1;

  always_comb begin
    hc_next = hc_reg;
    vc_next = vc_reg;
    if (pix_en_reg) begin
      if (hc_reg == H_LAST) begin
        hc_next = '0;
        vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
      end else begin
        hc_next = hc_reg + 1'b1;
      end
    end
  end

  always_comb begin
    visible = (hc_reg < HW'(H_VIS)) && (vc_reg < VW'(V_VIS));
    hs_raw  = !((hc_reg >= HW'(H_VIS + H_FP)) && (hc_reg < HW'(H_VIS + H_FP + H_SW)));
    vs_raw  = !((vc_reg >= VW'(V_VIS + V_FP)) && (vc_reg < VW'(V_VIS + V_FP + V_SW)));
    fx      = 15'(hc_reg >> SCALE_SH);
    fy      = 15'(vc_reg >> SCALE_SH);
    rd_addr_next = fy * 15'(FB_W) + fx;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign chan_on[gi] = rd_data[gi] & d_vis_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_en_reg  <= 1'b0;
      VGA_CLK     <= 1'b0;
      hc_reg      <= '0;
      vc_reg      <= '0;
      rd_addr     <= '0;
      d_vis_reg   <= 1'b0;
      d_hs_reg    <= 1'b1;
      d_vs_reg    <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      pix_en_reg <= ~pix_en_reg;
      // The DAC samples on the VGA_CLK rising edge, which lands one clk after
      // each output update and one clk before the next one.
      VGA_CLK    <= ~pix_en_reg;
      hc_reg     <= hc_next;
      vc_reg     <= vc_next;
      // pix_en is high on the wrap edge and low on the following one, so this
      // is a single-clk pulse.
      frame_start <= pix_en_reg && (hc_reg == H_LAST) && (vc_reg == V_LAST);
      if (pix_en_reg) begin
        // Holding the address in blanking keeps it inside the buffer.
        if (visible) begin
          rd_addr <= rd_addr_next;
        end
        d_vis_reg   <= visible;
        d_hs_reg    <= hs_raw;
        d_vs_reg    <= vs_raw;
        // rd_data has been valid for one clk when this edge samples it.
        VGA_R       <= {10{chan_on[2]}};
        VGA_G       <= {10{chan_on[1]}};
        VGA_B       <= {10{chan_on[0]}};
        VGA_BLANK_N <= d_vis_reg;
        VGA_HS      <= d_hs_reg;
        VGA_VS      <= d_vs_reg;
        vblank      <= (vc_next >= VW'(V_VIS));
      end
    end
  end

endmodule
